bsg_mem_1rw_sync_mask_write_bit_stream: RTL and testbench

Valid/ready front-end for a single-port, synchronous-read, bit-masked-write SRAM (`bsg_mem_1rw_sync_mask_write_bit`). It sits directly upstream of the memory. It accepts one read or write request per cycle and drives the memory port. It captures the one-cycle-late read data into a small output FIFO so the consumer may apply backpressure without losing data. An optional post-reset sweep zero-fills the array.

---
 rtl/bsg_mem_stream_pkg.sv | 15 +
 rtl/bsg_mem_stream_rdata_fifo.sv | 59 +++++
 rtl/bsg_mem_1rw_sync_mask_write_bit_stream.sv | 138 +++++++++++++
 tb/tb_bsg_mem_1rw_sync_mask_write_bit_stream.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_mem_stream_pkg.sv
// Shared types for the bsg_mem_1rw_sync_mask_write_bit_stream front-end.
// Holds the controller state enum and a safe clog2 helper for port widths.
package bsg_mem_stream_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Never returns 0 so a depth-1 structure still gets a 1-bit index.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_mem_stream_rdata_fifo.sv
// Flop-based circular FIFO that catches one-cycle-late SRAM read data.
// Storage and pointers reset to zero so data_o is 0 out of reset.
module bsg_mem_stream_rdata_fifo
  import bsg_mem_stream_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p = 2,
  localparam int ptr_width_lp = safe_clog2(els_p),
  localparam int count_width_lp = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      push_i,
  input  logic [width_p-1:0]        data_i,
  input  logic                      pop_i,
  output logic [width_p-1:0]        data_o,
  output logic                      v_o,
  output logic [count_width_lp-1:0] count_o
);

  logic [width_p-1:0]        mem_r [els_p];
  logic [ptr_width_lp-1:0]   rptr_r, wptr_r;
  logic [count_width_lp-1:0] count_r;
  logic                      full;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) mem_r[i] <= '0;
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_i) begin
        mem_r[wptr_r] <= data_i;
        wptr_r        <= ptr_inc(wptr_r);
      end
      if (pop_i) rptr_r <= ptr_inc(rptr_r);
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push_i && !pop_i)      count_r <= count_r + 1'b1;
      else if (pop_i && !push_i) count_r <= count_r - 1'b1;
    end
  end

  assign data_o  = mem_r[rptr_r];
  assign v_o     = (count_r != '0);
  assign full    = (count_r == count_width_lp'(els_p));
  assign count_o = count_r;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(push_i && full)) else $error("rdata fifo overflow push");
  end
`endif

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_stream.sv
// Valid/ready front-end for a 1rw sync-read bit-masked SRAM with a read-data FIFO.
// Define BSG_MEM_STREAM_ZERO_INIT_EN to zero-fill the array after reset.
module bsg_mem_1rw_sync_mask_write_bit_stream
  import bsg_mem_stream_pkg::*;
#(
  parameter int width_p = -1,
  parameter int els_p = -1,
  parameter int addr_width_lp = safe_clog2(els_p),
  parameter int fifo_els_p = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [width_p-1:0]       mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i,
  output logic                     init_done_o
);

  localparam int count_width_lp = $clog2(fifo_els_p + 1);

  state_e                    state_r, state_n;
  logic [addr_width_lp-1:0]  init_addr;
  logic                      rd_inflight_r;
  logic                      accept;
  logic                      fifo_v, fifo_pop;
  logic [count_width_lp-1:0] fifo_count;
  logic [count_width_lp:0]   occupancy;
  logic                      read_room;

`ifdef BSG_MEM_STREAM_ZERO_INIT_EN
  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
  logic [addr_width_lp-1:0] init_addr_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= ST_INIT;
      init_addr_r <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == ST_INIT)
        init_addr_r <= (init_addr_r == last_addr_lp) ? '0 : init_addr_r + 1'b1;
    end
  end

  always_comb begin
    state_n = state_r;
    if (state_r == ST_INIT && init_addr_r == last_addr_lp) state_n = ST_RUN;
  end

  assign init_addr   = init_addr_r;
  assign init_done_o = (state_r == ST_RUN);
`else
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= ST_RUN;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = ST_RUN;
  end

  assign init_addr   = '0;
  assign init_done_o = 1'b1;
`endif

  // Room for a read counts the in-flight word and any pop on this edge.
  assign fifo_pop  = yumi_i & fifo_v;
  assign occupancy = {1'b0, fifo_count} + (count_width_lp + 1)'(rd_inflight_r)
                   - (count_width_lp + 1)'(fifo_pop);
  assign read_room = (occupancy < (count_width_lp + 1)'(fifo_els_p));

  always_comb begin
    ready_o      = 1'b0;
    mem_v_o      = 1'b0;
    mem_w_o      = 1'b0;
    mem_addr_o   = addr_i;
    mem_data_o   = data_i;
    mem_w_mask_o = w_mask_i;
    if (!reset_i) begin
      if (state_r == ST_INIT) begin
        mem_v_o      = 1'b1;
        mem_w_o      = 1'b1;
        mem_addr_o   = init_addr;
        mem_data_o   = '0;
        mem_w_mask_o = '1;
      end else begin
        ready_o = w_i | read_room;
        mem_v_o = v_i & ready_o;
        mem_w_o = w_i;
      end
    end
  end

  assign accept = v_i & ready_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rd_inflight_r <= 1'b0;
    else         rd_inflight_r <= accept & ~w_i;
  end

  bsg_mem_stream_rdata_fifo #(
    .width_p(width_p),
    .els_p  (fifo_els_p)
  ) rdata_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (rd_inflight_r),
    .data_i (mem_data_i),
    .pop_i  (fifo_pop),
    .data_o (data_o),
    .v_o    (fifo_v),
    .count_o(fifo_count)
  );

  assign v_o = fifo_v;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (accept) assert (32'(addr_i) < els_p) else $error("request address out of range");
      assert (!yumi_i || fifo_v) else $error("yumi_i without v_o");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_stream.sv
// Directed bench for the SRAM stream front-end with a behavioural masked SRAM.
// Sweep checks are built only when BSG_MEM_STREAM_ZERO_INIT_EN is defined.
module tb_bsg_mem_1rw_sync_mask_write_bit_stream;

  localparam int W = 16;
  localparam int ELS = 7;
  localparam int AW = 3;
  localparam int FIFO = 2;
`ifdef BSG_MEM_STREAM_ZERO_INIT_EN
  localparam logic [W-1:0] SEED = 16'hDEAD;
`else
  localparam logic [W-1:0] SEED = 16'h0000;
`endif

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          v_i, w_i;
  logic [AW-1:0] addr_i;
  logic [W-1:0]  data_i, w_mask_i;
  logic          ready_o, v_o;
  logic [W-1:0]  data_o;
  logic          yumi_en, yumi_i;
  logic          mem_v_o, mem_w_o;
  logic [AW-1:0] mem_addr_o;
  logic [W-1:0]  mem_data_o, mem_w_mask_o;
  logic [W-1:0]  mem_data_i;
  logic          init_done_o;
  logic          model_init;
  logic [W-1:0]  model_mem [ELS];
  logic [W-1:0]  exp_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  assign yumi_i = yumi_en & v_o;

  // Behavioural single-port SRAM: masked write, registered read.
  always @(posedge clk_i) begin
    if (model_init) begin
      for (int i = 0; i < ELS; i++) model_mem[i] <= SEED;
      mem_data_i <= '0;
    end else if (mem_v_o) begin
      if (mem_w_o)
        model_mem[mem_addr_o] <= (model_mem[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
      else
        mem_data_i <= model_mem[mem_addr_o];
    end
  end

  bsg_mem_1rw_sync_mask_write_bit_stream #(
    .width_p   (W),
    .els_p     (ELS),
    .fifo_els_p(FIFO)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .w_i         (w_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .w_mask_i    (w_mask_i),
    .ready_o     (ready_o),
    .v_o         (v_o),
    .data_o      (data_o),
    .yumi_i      (yumi_i),
    .mem_v_o     (mem_v_o),
    .mem_w_o     (mem_w_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_w_mask_o(mem_w_mask_o),
    .mem_data_i  (mem_data_i),
    .init_done_o (init_done_o)
  );

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic idle();
    v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; w_mask_i = '0;
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic [W-1:0] m);
    v_i = v; w_i = w; addr_i = a; data_i = d; w_mask_i = m;
  endtask

  task automatic test_reset();
    logic exp_done;
`ifdef BSG_MEM_STREAM_ZERO_INIT_EN
    exp_done = 1'b0;
`else
    exp_done = 1'b1;
`endif
    reset_i = 1'b1; model_init = 1'b1; yumi_en = 1'b0;
    drive(1'b1, 1'b1, 3'd1, 16'h1234, 16'hFFFF);
    step(); step(); #1;
    vectors++;
    if ({ready_o, v_o, mem_v_o, data_o, init_done_o} !== {1'b0, 1'b0, 1'b0, 16'h0, exp_done}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got rdy=%b v=%b memv=%b data=%h done=%b want 0 0 0 0000 %b",
               ready_o, v_o, mem_v_o, data_o, init_done_o, exp_done);
    end
    idle();
    step();
    reset_i = 1'b0; model_init = 1'b0;
  endtask

`ifdef BSG_MEM_STREAM_ZERO_INIT_EN
  task automatic test_sweep();
    for (int c = 0; c < ELS; c++) begin
      drive(1'b1, 1'b0, 3'd2, 16'h0, 16'h0);
      #1;
      vectors++;
      if ({mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o, ready_o, init_done_o}
          !== {1'b1, 1'b1, 3'(c), 16'h0000, 16'hFFFF, 1'b0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL sweep_cycle%0d: got v=%b w=%b a=%0d d=%h m=%h rdy=%b done=%b want 1 1 %0d 0000 ffff 0 0",
                 c, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o, ready_o, init_done_o, c);
      end
      step();
    end
    idle(); #1;
    vectors++;
    if ({init_done_o, ready_o} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL sweep_done: got done=%b rdy=%b want 1 1", init_done_o, ready_o);
    end
    drive(1'b1, 1'b0, 3'd3, 16'h0, 16'h0);
    step(); idle(); step(); #1;
    vectors++;
    if ({v_o, data_o} !== {1'b1, 16'h0000}) begin
      miscompares++;
      $display("[TB] FAIL sweep_read3: got v=%b data=%h want 1 0000", v_o, data_o);
    end
    yumi_en = 1'b1; step(); yumi_en = 1'b0;
  endtask

  task automatic test_reset_during_init();
    reset_i = 1'b1; step(); reset_i = 1'b0;
    step(); step(); step(); #1;
    vectors++;
    if ({mem_v_o, mem_addr_o} !== {1'b1, 3'd3}) begin
      miscompares++;
      $display("[TB] FAIL init_at3: got v=%b a=%0d want 1 3", mem_v_o, mem_addr_o);
    end
    reset_i = 1'b1; #1;
    vectors++;
    if ({mem_v_o, ready_o, init_done_o} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL init_reset: got memv=%b rdy=%b done=%b want 0 0 0", mem_v_o, ready_o, init_done_o);
    end
    step(); reset_i = 1'b0; #1;
    vectors++;
    if ({mem_v_o, mem_addr_o, init_done_o} !== {1'b1, 3'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL init_restart: got v=%b a=%0d done=%b want 1 0 0", mem_v_o, mem_addr_o, init_done_o);
    end
    repeat (ELS) step();
    #1;
    vectors++;
    if (init_done_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL init_redone: got %b want 1", init_done_o);
    end
  endtask
`else
  task automatic test_no_init();
    idle(); #1;
    vectors++;
    if ({init_done_o, ready_o} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL no_init_first_cycle: got done=%b rdy=%b want 1 1", init_done_o, ready_o);
    end
  endtask
`endif

  task automatic test_write_read();
    drive(1'b1, 1'b1, 3'd5, 16'hFFFF, 16'h00FF); #1;
    vectors++;
    if ({ready_o, mem_v_o, mem_w_o, mem_addr_o, mem_w_mask_o} !== {1'b1, 1'b1, 1'b1, 3'd5, 16'h00FF}) begin
      miscompares++;
      $display("[TB] FAIL wr_port: got rdy=%b v=%b w=%b a=%0d m=%h want 1 1 1 5 00ff",
               ready_o, mem_v_o, mem_w_o, mem_addr_o, mem_w_mask_o);
    end
    step();
    drive(1'b1, 1'b0, 3'd5, 16'h0, 16'h0); #1;
    vectors++;
    if ({ready_o, mem_v_o, mem_w_o} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL rd_accept: got rdy=%b v=%b w=%b want 1 1 0", ready_o, mem_v_o, mem_w_o);
    end
    step(); idle(); #1;
    vectors++;
    if (v_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rd_latency_n1: got v=%b want 0", v_o);
    end
    step(); #1;
    vectors++;
    if ({v_o, data_o} !== {1'b1, 16'h00FF}) begin
      miscompares++;
      $display("[TB] FAIL rd_masked_data: got v=%b data=%h want 1 00ff", v_o, data_o);
    end
    yumi_en = 1'b1; step(); yumi_en = 1'b0; #1;
    vectors++;
    if (v_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rd_drained: got v=%b want 0", v_o);
    end
  endtask

  task automatic test_preload();
    for (int a = 0; a < ELS; a++) begin
      drive(1'b1, 1'b1, 3'(a), 16'hA000 | 16'(a), 16'hFFFF); #1;
      vectors++;
      if (ready_o !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL preload_ready%0d: got %b want 1", a, ready_o);
      end
      step();
    end
    idle();
  endtask

  task automatic test_backpressure();
    yumi_en = 1'b0;
    drive(1'b1, 1'b0, 3'd1, 16'h0, 16'h0); step();
    drive(1'b1, 1'b0, 3'd2, 16'h0, 16'h0); #1;
    vectors++;
    if (ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_second_read: got rdy=%b want 1", ready_o);
    end
    step();
    drive(1'b1, 1'b0, 3'd3, 16'h0, 16'h0); #1;
    vectors++;
    if ({ready_o, mem_v_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL bp_third_stalled: got rdy=%b memv=%b want 0 0", ready_o, mem_v_o);
    end
    drive(1'b1, 1'b1, 3'd0, 16'hA000, 16'hFFFF); #1;
    vectors++;
    if ({ready_o, mem_v_o, mem_w_o} !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL bp_write_passes: got rdy=%b memv=%b w=%b want 1 1 1", ready_o, mem_v_o, mem_w_o);
    end
    step();
    drive(1'b1, 1'b0, 3'd3, 16'h0, 16'h0); #1;
    vectors++;
    if (ready_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_full_no_yumi: got rdy=%b want 0", ready_o);
    end
    yumi_en = 1'b1; #1;
    vectors++;
    if ({ready_o, v_o, data_o} !== {1'b1, 1'b1, 16'hA001}) begin
      miscompares++;
      $display("[TB] FAIL bp_yumi_accept: got rdy=%b v=%b data=%h want 1 1 a001", ready_o, v_o, data_o);
    end
    step(); idle(); #1;
    vectors++;
    if ({v_o, data_o} !== {1'b1, 16'hA002}) begin
      miscompares++;
      $display("[TB] FAIL bp_order2: got v=%b data=%h want 1 a002", v_o, data_o);
    end
    step(); #1;
    vectors++;
    if ({v_o, data_o} !== {1'b1, 16'hA003}) begin
      miscompares++;
      $display("[TB] FAIL bp_order3: got v=%b data=%h want 1 a003", v_o, data_o);
    end
    step(); yumi_en = 1'b0; #1;
    vectors++;
    if (v_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_empty: got v=%b want 0", v_o);
    end
  endtask

  task automatic test_back_to_back();
    yumi_en = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i < 20) drive(1'b1, 1'b0, 3'(i % ELS), 16'h0, 16'h0);
      else        idle();
      #1;
      if (i < 20) begin
        vectors++;
        if (ready_o !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL stream_ready%0d: got %b want 1", i, ready_o);
        end
      end
      if (i >= 2) begin
        exp_data = 16'hA000 | 16'((i - 2) % ELS);
        vectors++;
        if ({v_o, data_o} !== {1'b1, exp_data}) begin
          miscompares++;
          $display("[TB] FAIL stream_data%0d: got v=%b data=%h want 1 %h", i, v_o, data_o, exp_data);
        end
      end
      step();
    end
    yumi_en = 1'b0; #1;
    vectors++;
    if (v_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stream_drained: got v=%b want 0", v_o);
    end
  endtask

  task automatic test_reset_inflight();
    yumi_en = 1'b0;
    drive(1'b1, 1'b0, 3'd4, 16'h0, 16'h0); #1;
    vectors++;
    if (ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL inflight_accept: got %b want 1", ready_o);
    end
    step();
    reset_i = 1'b1; idle(); #1;
    vectors++;
    if ({v_o, ready_o, mem_v_o} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL inflight_reset: got v=%b rdy=%b memv=%b want 0 0 0", v_o, ready_o, mem_v_o);
    end
    step(); reset_i = 1'b0;
    for (int c = 0; c < ELS + 3; c++) begin
      #1;
      vectors++;
      if (v_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL inflight_stale%0d: got v=%b data=%h want v=0", c, v_o, data_o);
      end
`ifdef BSG_MEM_STREAM_ZERO_INIT_EN
      if (c < ELS) begin
        vectors++;
        if (mem_addr_o !== 3'(c)) begin
          miscompares++;
          $display("[TB] FAIL inflight_sweep%0d: got a=%0d want %0d", c, mem_addr_o, c);
        end
      end
`endif
      step();
    end
    #1;
    vectors++;
    if ({init_done_o, ready_o} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL inflight_recovered: got done=%b rdy=%b want 1 1", init_done_o, ready_o);
    end
  endtask

  initial begin
    idle();
    test_reset();
`ifdef BSG_MEM_STREAM_ZERO_INIT_EN
    test_sweep();
    test_reset_during_init();
`else
    test_no_init();
`endif
    test_write_read();
    test_preload();
    test_backpressure();
    test_back_to_back();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
